// File: rtl/fb_access_arbiter.sv
// Frame buffer access arbiter: display-priority read/camera-write sequencer with starvation guard.
// Optional FB_CLEAR_EN adds a full-frame clear sweep (clear_start/clear_busy/clear_done).
module fb_access_arbiter #(
    parameter int WIDTH      = 100,
    parameter int HEIGHT     = 100,
    parameter int XW         = 7,
    parameter int YW         = 7,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cam_valid,
    output logic          cam_ready,
    input  logic [XW-1:0] cam_x,
    input  logic [YW-1:0] cam_y,
    input  logic          cam_pix,
    input  logic          disp_req,
    output logic          disp_gnt,
    input  logic [XW-1:0] disp_x,
    input  logic [YW-1:0] disp_y,
    output logic          disp_rvalid,
    output logic          disp_pix,
    output logic [XW-1:0] ram_x,
    output logic [YW-1:0] ram_y,
    output logic          ram_din,
    output logic          ram_write,
    input  logic          ram_dout
`ifdef FB_CLEAR_EN
   ,input  logic          clear_start,
    output logic          clear_busy,
    output logic          clear_done
`endif
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] cnt_q, cnt_d;
    logic       rvalid_q, pix_q;
    logic       cam_gnt, dsp_gnt;
    logic       cam_inr, dsp_inr;
    logic       in_clear;

`ifdef FB_CLEAR_EN
    typedef enum logic {ARB, CLEAR} state_t;
    state_t        state_q, state_d;
    logic [XW-1:0] clr_x_q, clr_x_d;
    logic [YW-1:0] clr_y_q, clr_y_d;
    logic          done_q, done_d;

    assign in_clear   = (state_q == CLEAR);
    assign clear_busy = in_clear;
    assign clear_done = done_q;

    always_comb begin
        state_d = state_q;
        clr_x_d = clr_x_q;
        clr_y_d = clr_y_q;
        done_d  = 1'b0;
        case (state_q)
            ARB: begin
                if (reset_n && clear_start) begin
                    state_d = CLEAR;
                    clr_x_d = '0;
                    clr_y_d = '0;
                end
            end
            CLEAR: begin
                if (clr_x_q == XW'(WIDTH - 1)) begin
                    clr_x_d = '0;
                    if (clr_y_q == YW'(HEIGHT - 1)) begin
                        state_d = ARB;
                        done_d  = 1'b1;
                    end else begin
                        clr_y_d = clr_y_q + 1'b1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB;
            clr_x_q <= '0;
            clr_y_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_x_q <= clr_x_d;
            clr_y_q <= clr_y_d;
            done_q  <= done_d;
        end
    end
`else
    assign in_clear = 1'b0;
`endif

    assign cam_inr = (int'(cam_x) < WIDTH) && (int'(cam_y) < HEIGHT);
    assign dsp_inr = (int'(disp_x) < WIDTH) && (int'(disp_y) < HEIGHT);

    // Grants are forced low during reset so the RAM never sees a stray write.
    always_comb begin
        cam_gnt = 1'b0;
        dsp_gnt = 1'b0;
        if (reset_n && !in_clear) begin
            if (cam_valid && disp_req) begin
                if (cnt_q >= STARVE_LIM) cam_gnt = 1'b1;
                else                     dsp_gnt = 1'b1;
            end else if (cam_valid) begin
                cam_gnt = 1'b1;
            end else if (disp_req) begin
                dsp_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!cam_valid || cam_gnt || in_clear) cnt_d = '0;
        else if (dsp_gnt)                      cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        ram_x     = '0;
        ram_y     = '0;
        ram_din   = 1'b0;
        ram_write = 1'b0;
        if (cam_gnt) begin
            ram_x     = cam_x;
            ram_y     = cam_y;
            ram_din   = cam_pix;
            ram_write = cam_inr;
        end else if (dsp_gnt) begin
            ram_x   = disp_x;
            ram_y   = disp_y;
            ram_din = cam_pix;
        end
`ifdef FB_CLEAR_EN
        if (in_clear) begin
            ram_x     = clr_x_q;
            ram_y     = clr_y_q;
            ram_din   = 1'b0;
            ram_write = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            pix_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rvalid_q <= dsp_gnt;
            if (dsp_gnt) pix_q <= dsp_inr & ram_dout;
        end
    end

    assign cam_ready   = cam_gnt;
    assign disp_gnt    = dsp_gnt;
    assign disp_rvalid = rvalid_q & ~in_clear;
    assign disp_pix    = pix_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Scoreboard bench for fb_access_arbiter with a behavioural 100x100 RAM; clear tests under FB_CLEAR_EN.
module tb_fb_access_arbiter;

    localparam int W = 100, H = 100, XW = 7, YW = 7, SM = 8;

    logic clk = 1'b0, reset_n = 1'b0;
    logic cam_valid = 0, cam_pix = 0, disp_req = 0;
    logic [XW-1:0] cam_x = '0, disp_x = '0;
    logic [YW-1:0] cam_y = '0, disp_y = '0;
    logic cam_ready, disp_gnt, disp_rvalid, disp_pix, ram_din, ram_write, ram_dout;
    logic [XW-1:0] ram_x;
    logic [YW-1:0] ram_y;
`ifdef FB_CLEAR_EN
    logic clear_start = 0, clear_busy, clear_done;
`endif

    fb_access_arbiter #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset_n(reset_n),
        .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_x(cam_x), .cam_y(cam_y), .cam_pix(cam_pix),
        .disp_req(disp_req), .disp_gnt(disp_gnt), .disp_x(disp_x), .disp_y(disp_y),
        .disp_rvalid(disp_rvalid), .disp_pix(disp_pix),
        .ram_x(ram_x), .ram_y(ram_y), .ram_din(ram_din), .ram_write(ram_write), .ram_dout(ram_dout)
`ifdef FB_CLEAR_EN
       ,.clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit f_init(int x, int y);
        return bit'(((x ^ y ^ (x >> 2)) & 1) != 0);
    endfunction

    function automatic bit inr(int x, int y);
        return (x < W) && (y < H);
    endfunction

    // RAM model; out-of-range reads return 1 so the DUT must mask them itself.
    logic mem [H][W];
    assign ram_dout = (int'(ram_x) < W && int'(ram_y) < H) ? mem[ram_y][ram_x] : 1'b1;
    initial begin
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) mem[y][x] = f_init(x, y);
        forever begin
            @(posedge clk);
            if (ram_write && int'(ram_x) < W && int'(ram_y) < H) mem[ram_y][ram_x] <= ram_din;
        end
    end

    int n_tests = 0, n_fail = 0;
    int mcnt = 0, cam_gnts = 0;
    bit shadow [H][W];
    bit exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered and left at posedge+1: drive, check combinational side, then registered side.
    task automatic step(input logic v, input int cx, input int cy, input logic p,
                        input logic r, input int dx, input int dy);
        bit eg_c, eg_d;
        int ex, ey;
        cam_valid = v; cam_x = XW'(cx); cam_y = YW'(cy); cam_pix = p;
        disp_req = r; disp_x = XW'(dx); disp_y = YW'(dy);
        eg_c = 0; eg_d = 0;
        if (v && r) begin
            if (mcnt >= SM) eg_c = 1; else eg_d = 1;
        end else if (v) eg_c = 1;
        else if (r) eg_d = 1;
        ex = eg_c ? cx : (eg_d ? dx : 0);
        ey = eg_c ? cy : (eg_d ? dy : 0);
        #2;
        chk("cam_ready", cam_ready, eg_c);
        chk("disp_gnt", disp_gnt, eg_d);
        chk("ram_x", ram_x, ex);
        chk("ram_y", ram_y, ey);
        chk("ram_write", ram_write, eg_c && inr(cx, cy));
        if (eg_c) chk("ram_din", ram_din, p);
        if (cam_ready) cam_gnts++;
        if (eg_d) exp_q.push_back(inr(dx, dy) ? shadow[dy][dx] : 1'b0);
        if (!v || eg_c) mcnt = 0; else if (eg_d) mcnt++;
        @(posedge clk);
        if (eg_c && inr(cx, cy)) shadow[cy][cx] = p;
        #1;
        chk("disp_rvalid", disp_rvalid, eg_d);
        if (disp_rvalid) begin
            if (exp_q.size() > 0) chk("disp_pix", disp_pix, exp_q.pop_front());
            else chk("rvalid_no_expect", 1, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) shadow[y][x] = f_init(x, y);

        // Reset with both requesters active: everything quiet.
        cam_valid = 1; cam_x = 5; cam_y = 5; disp_req = 1; disp_x = 6; disp_y = 6;
        #3;
        chk("rst_cam_ready", cam_ready, 0);
        chk("rst_disp_gnt", disp_gnt, 0);
        chk("rst_ram_write", ram_write, 0);
        chk("rst_ram_x", ram_x, 0);
        chk("rst_rvalid", disp_rvalid, 0);
        chk("rst_pix", disp_pix, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

        step(1, 10, 20, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 10, 20);
        step(1, 5, 7, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 7);
        step(1, 10, 20, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 10, 20);
        step(0, 0, 0, 0, 0, 0, 0);

        // Starvation: 8 display grants then 1 camera grant, repeating.
        cam_gnts = 0;
        for (int i = 0; i < 27; i++) step(1, i, 40, i[0], 1, 60 + i, 33);
        chk("starve_cam_gnts", cam_gnts, 3);
        step(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 97 + i % 3, 99 - i);

        // Out-of-range coordinates.
        step(1, 100, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3, 100);
        step(0, 0, 0, 0, 1, 127, 0);
        step(1, 99, 99, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 99, 99);

        // Reset arriving while a read is granted, after partial starvation.
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, 2, 2);
        cam_valid = 0; disp_req = 1; disp_x = 8; disp_y = 8;
        #2 reset_n = 0;
        #1 chk("midrst_disp_gnt", disp_gnt, 0);
        @(posedge clk);
        #1 chk("midrst_rvalid", disp_rvalid, 0);
        reset_n = 1;
        mcnt = 0;
        for (int i = 0; i < 9; i++) step(1, 30, i, 1, 1, 31, i);
        step(1, 30, 9, 1, 1, 31, 9);
        step(0, 0, 0, 0, 0, 0, 0);

`ifdef FB_CLEAR_EN
        begin
            int errs;
            clear_start = 1;
            step(0, 0, 0, 0, 0, 0, 0);
            clear_start = 0; cam_valid = 1; disp_req = 1; disp_x = 42; disp_y = 17;
            errs = 0;
            for (int i = 0; i < W * H; i++) begin
                #1;
                if (ram_write !== 1 || ram_din !== 0 || int'(ram_x) != i % W || int'(ram_y) != i / W ||
                    cam_ready !== 0 || disp_gnt !== 0 || disp_rvalid !== 0 ||
                    clear_busy !== 1 || clear_done !== 0) errs++;
                if (i == 0 || i == W * H - 1) clear_start = 1; else clear_start = 0;
                @(posedge clk); #1;
            end
            clear_start = 0;
            chk("sweep_errs", errs, 0);
            #1;
            chk("clear_done", clear_done, 1);
            chk("clear_busy_end", clear_busy, 0);
            chk("post_clear_gnt", disp_gnt, 1);
            @(posedge clk); #1;
            chk("clear_done_once", clear_done, 0);
            chk("post_clear_rvalid", disp_rvalid, 1);
            chk("post_clear_pix", disp_pix, 0);
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) shadow[y][x] = 0;
            mcnt = 1;
            step(0, 0, 0, 0, 0, 0, 0);
            step(1, 50, 50, 1, 0, 0, 0);

            // Reset partway through a second sweep.
            clear_start = 1;
            step(0, 0, 0, 0, 0, 0, 0);
            clear_start = 0;
            repeat (500) @(posedge clk);
            #1 reset_n = 0;
            #1;
            chk("abort_busy", clear_busy, 0);
            chk("abort_done", clear_done, 0);
            @(posedge clk); #1 reset_n = 1;
            errs = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (clear_done !== 0 || clear_busy !== 0) errs++;
            end
            chk("abort_no_done", errs, 0);
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < W; x++) shadow[y][x] = 0;
            mcnt = 0;
            step(0, 0, 0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 1, 50, 50);
            step(1, 4, 4, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0, 0);
        end
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
